// File: rtl/sand_pkg.sv
// Shared types and screen geometry for the sand engine, VGA timing and frame scheduler.
package sand_pkg;

    localparam int SAND_ACTIVE_COLUMNS = 640;
    localparam int SAND_ACTIVE_ROWS    = 480;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DRAIN,
        ST_SAND_START,
        ST_SAND_RUN
    } sched_state_e;

endpackage

// File: rtl/sand_frame_scheduler_brush_fifo.sv
// brush_fifo: synchronous FIFO for queued brush writes; head is the combinational read of the oldest entry.
module brush_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 20,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] count_o,
    output logic [WIDTH-1:0] head_o
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign full_o  = (count_o == CNT_W'(DEPTH));
    assign empty_o = (count_o == '0);
    assign head_o  = mem[rd_ptr];
    assign push_ok = push_i & ~full_o;
    assign pop_ok  = pop_i & ~empty_o;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_o <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push_ok, pop_ok})
                2'b10:   count_o <= count_o + CNT_W'(1);
                2'b01:   count_o <= count_o - CNT_W'(1);
                default: count_o <= count_o;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok) mem[wr_ptr] <= push_data_i;
    end

endmodule

// File: rtl/sand_frame_scheduler.sv
// Per-vblank owner of the pixel RAM write port: drains brush writes, then runs one sand pass.
// Optional SAND_PAUSE_EN adds pause_i, which skips the sand pass for a frame.
module sand_frame_scheduler
    import sand_pkg::*;
#(
    parameter int ACTIVE_COLUMNS = SAND_ACTIVE_COLUMNS,
    parameter int ACTIVE_ROWS    = SAND_ACTIVE_ROWS,
    parameter int ADDR_WIDTH     = $clog2(ACTIVE_COLUMNS * ACTIVE_ROWS),
    parameter int DATA_WIDTH     = 1,
    parameter int BRUSH_DEPTH    = 8
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  vblank_i,
`ifdef SAND_PAUSE_EN
    input  logic                  pause_i,
`endif
    input  logic [ADDR_WIDTH-1:0] disp_addr_i,
    input  logic                  brush_valid_i,
    input  logic [ADDR_WIDTH-1:0] brush_addr_i,
    input  logic [DATA_WIDTH-1:0] brush_data_i,
    output logic                  brush_ready_o,
    output logic                  sand_start_o,
    input  logic [ADDR_WIDTH-1:0] sand_read_addr_i,
    input  logic [ADDR_WIDTH-1:0] sand_write_addr_i,
    input  logic [DATA_WIDTH-1:0] sand_write_data_i,
    input  logic                  sand_wr_ena_i,
    input  logic                  sand_done_i,
    output logic [ADDR_WIDTH-1:0] ram_read_addr_o,
    output logic [ADDR_WIDTH-1:0] ram_write_addr_o,
    output logic [DATA_WIDTH-1:0] ram_write_data_o,
    output logic                  ram_wr_ena_o,
    output logic                  busy_o,
    output logic                  overrun_o,
    output logic [15:0]           frame_count_o
);

    localparam int ENTRY_W = ADDR_WIDTH + DATA_WIDTH;
    localparam int CNT_W   = $clog2(BRUSH_DEPTH) + 1;

    sched_state_e          state;
    sched_state_e          state_n;
    logic                  vblank_q;
    logic                  rise_q;
    logic [CNT_W-1:0]      drain_cnt;
    logic                  fifo_pop;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [CNT_W-1:0]      fifo_count;
    logic [ENTRY_W-1:0]    fifo_head;
    logic [ADDR_WIDTH-1:0] head_addr;
    logic [DATA_WIDTH-1:0] head_data;
    logic                  skip_now;
    logic                  skip_q;

    brush_fifo #(
        .DEPTH (BRUSH_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_brush_fifo (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .push_i      (brush_valid_i),
        .push_data_i ({brush_addr_i, brush_data_i}),
        .pop_i       (fifo_pop),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .count_o     (fifo_count),
        .head_o      (fifo_head)
    );

    assign {head_addr, head_data} = fifo_head;
    assign brush_ready_o = ~fifo_full;
    assign busy_o        = (state != ST_IDLE);

`ifdef SAND_PAUSE_EN
    // Pause is sampled once per frame, at the detected rise.
    assign skip_now = pause_i;
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i)                         skip_q <= 1'b0;
        else if (state == ST_IDLE && rise_q) skip_q <= pause_i;
    end
`else
    assign skip_now = 1'b0;
    assign skip_q   = 1'b0;
`endif

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state         <= ST_IDLE;
            vblank_q      <= 1'b0;
            rise_q        <= 1'b0;
            overrun_o     <= 1'b0;
            drain_cnt     <= '0;
            frame_count_o <= '0;
        end else begin
            state     <= state_n;
            vblank_q  <= vblank_i;
            rise_q    <= vblank_i & ~vblank_q;
            overrun_o <= ~vblank_i & vblank_q & busy_o;
            if (state == ST_IDLE && rise_q)
                drain_cnt <= fifo_count;
            else if (state == ST_DRAIN)
                drain_cnt <= drain_cnt - CNT_W'(1);
            if (state == ST_SAND_RUN && sand_done_i)
                frame_count_o <= frame_count_o + 16'd1;
        end
    end

    always_comb begin
        state_n          = state;
        fifo_pop         = 1'b0;
        sand_start_o     = 1'b0;
        ram_read_addr_o  = disp_addr_i;
        ram_write_addr_o = '0;
        ram_write_data_o = '0;
        ram_wr_ena_o     = 1'b0;
        case (state)
            ST_IDLE: begin
                // A rise seen while busy is simply dropped: rise_q only acts here.
                if (rise_q) begin
                    if (!fifo_empty)   state_n = ST_DRAIN;
                    else if (skip_now) state_n = ST_IDLE;
                    else               state_n = ST_SAND_START;
                end
            end
            ST_DRAIN: begin
                fifo_pop         = 1'b1;
                ram_wr_ena_o     = 1'b1;
                ram_write_addr_o = head_addr;
                ram_write_data_o = head_data;
                if (drain_cnt == CNT_W'(1))
                    state_n = skip_q ? ST_IDLE : ST_SAND_START;
            end
            ST_SAND_START: begin
                sand_start_o = 1'b1;
                state_n      = ST_SAND_RUN;
            end
            ST_SAND_RUN: begin
                ram_read_addr_o  = sand_read_addr_i;
                ram_write_addr_o = sand_write_addr_i;
                ram_write_data_o = sand_write_data_i;
                ram_wr_ena_o     = sand_wr_ena_i;
                if (sand_done_i) state_n = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_sand_frame_scheduler.sv
// Randomized bench for sand_frame_scheduler against a queue-based frame model.
module tb_sand_frame_scheduler;

    localparam int AW = 19;
    localparam int DW = 1;
    localparam int D  = 8;
    localparam int MAXPIX = 640 * 480 - 1;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } ent_t;

    logic          clk_i = 1'b0;
    logic          reset_i = 1'b0;
    logic          vblank_i = 1'b0;
    logic          pause_i = 1'b0;
    logic [AW-1:0] disp_addr_i = '0;
    logic          brush_valid_i = 1'b0;
    logic [AW-1:0] brush_addr_i = '0;
    logic [DW-1:0] brush_data_i = '0;
    logic          brush_ready_o;
    logic          sand_start_o;
    logic [AW-1:0] sand_read_addr_i = '0;
    logic [AW-1:0] sand_write_addr_i = '0;
    logic [DW-1:0] sand_write_data_i = '0;
    logic          sand_wr_ena_i = 1'b0;
    logic          sand_done_i = 1'b0;
    logic [AW-1:0] ram_read_addr_o;
    logic [AW-1:0] ram_write_addr_o;
    logic [DW-1:0] ram_write_data_o;
    logic          ram_wr_ena_o;
    logic          busy_o;
    logic          overrun_o;
    logic [15:0]   frame_count_o;

    int checks = 0;
    int errors = 0;

    ent_t        model_q[$];
    int          exp_frames;
    ent_t        obs_w[$];
    int          obs_wc[$];
    int          start_cyc, start_n;
    logic        busy_done, ovr_seen, inj_ready;

    sand_frame_scheduler dut (
        .clk_i             (clk_i),
        .reset_i           (reset_i),
        .vblank_i          (vblank_i),
`ifdef SAND_PAUSE_EN
        .pause_i           (pause_i),
`endif
        .disp_addr_i       (disp_addr_i),
        .brush_valid_i     (brush_valid_i),
        .brush_addr_i      (brush_addr_i),
        .brush_data_i      (brush_data_i),
        .brush_ready_o     (brush_ready_o),
        .sand_start_o      (sand_start_o),
        .sand_read_addr_i  (sand_read_addr_i),
        .sand_write_addr_i (sand_write_addr_i),
        .sand_write_data_i (sand_write_data_i),
        .sand_wr_ena_i     (sand_wr_ena_i),
        .sand_done_i       (sand_done_i),
        .ram_read_addr_o   (ram_read_addr_o),
        .ram_write_addr_o  (ram_write_addr_o),
        .ram_write_data_o  (ram_write_data_o),
        .ram_wr_ena_o      (ram_wr_ena_o),
        .busy_o            (busy_o),
        .overrun_o         (overrun_o),
        .frame_count_o     (frame_count_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    function automatic ent_t rand_ent();
        ent_t e;
        e.a = AW'($urandom_range(0, MAXPIX));
        e.d = DW'($urandom);
        return e;
    endfunction

    // Offers one entry; returns the ready seen while valid was held.
    task automatic push(input ent_t e, output logic rdy);
        brush_valid_i = 1'b1;
        brush_addr_i  = e.a;
        brush_data_i  = e.d;
        #1;
        rdy = brush_ready_o;
        tick();
        brush_valid_i = 1'b0;
    endtask

    // Raises vblank, records every RAM write and start pulse, answers the start with a done.
    task automatic run_frame(input logic inject, input ent_t inj);
        logic injected;
        obs_w.delete();
        obs_wc.delete();
        start_cyc = -1; start_n = 0; busy_done = 1'b1; ovr_seen = 1'b0;
        inj_ready = 1'b0; injected = 1'b0;
        vblank_i = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            tick();
            brush_valid_i = 1'b0;
            sand_done_i   = 1'b0;
            if (overrun_o) ovr_seen = 1'b1;
            if (ram_wr_ena_o) begin
                obs_w.push_back('{a: ram_write_addr_o, d: ram_write_data_o});
                obs_wc.push_back(c);
            end
            if (sand_start_o) begin
                start_n++;
                if (start_cyc < 0) start_cyc = c;
            end
            if (start_cyc > 0 && c == start_cyc + 1) sand_done_i = 1'b1;
            if (start_cyc > 0 && c == start_cyc + 2) busy_done = busy_o;
            if (inject && !injected && obs_w.size() == 2) begin
                brush_valid_i = 1'b1;
                brush_addr_i  = inj.a;
                brush_data_i  = inj.d;
                inj_ready     = brush_ready_o;
                injected      = 1'b1;
            end
        end
        vblank_i = 1'b0;
        tick(); if (overrun_o) ovr_seen = 1'b1;
        tick(); if (overrun_o) ovr_seen = 1'b1;
    endtask

    task automatic test_reset();
        reset_i = 1'b1;
        disp_addr_i = AW'($urandom_range(0, MAXPIX));
        #3;
        checks++; if (brush_ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready got %0b want 1", brush_ready_o); end
        checks++; if (sand_start_o !== 1'b0) begin errors++; $display("FAIL reset_start got %0b want 0", sand_start_o); end
        checks++; if (ram_wr_ena_o !== 1'b0 || ram_write_addr_o !== '0 || ram_write_data_o !== '0) begin errors++; $display("FAIL reset_wport got en=%0b a=%0d d=%0d want 0/0/0", ram_wr_ena_o, ram_write_addr_o, ram_write_data_o); end
        checks++; if (busy_o !== 1'b0 || overrun_o !== 1'b0) begin errors++; $display("FAIL reset_busy_ovr got %0b/%0b want 0/0", busy_o, overrun_o); end
        checks++; if (frame_count_o !== 16'd0) begin errors++; $display("FAIL reset_frames got %0d want 0", frame_count_o); end
        checks++; if (ram_read_addr_o !== disp_addr_i) begin errors++; $display("FAIL reset_rdaddr got %0d want %0d", ram_read_addr_o, disp_addr_i); end
        tick(); tick();
        reset_i = 1'b0;
        tick();
        model_q.delete();
        exp_frames = 0;
    endtask

    task automatic test_empty_frame();
        run_frame(1'b0, '0);
        exp_frames++;
        checks++; if (obs_w.size() != 0) begin errors++; $display("FAIL empty_writes got %0d want 0", obs_w.size()); end
        checks++; if (start_cyc != 2 || start_n != 1) begin errors++; $display("FAIL empty_start got cyc=%0d n=%0d want cyc=2 n=1", start_cyc, start_n); end
        checks++; if (busy_done !== 1'b0) begin errors++; $display("FAIL empty_busy_after_done got %0b want 0", busy_done); end
        checks++; if (frame_count_o !== 16'(exp_frames)) begin errors++; $display("FAIL empty_frames got %0d want %0d", frame_count_o, exp_frames); end
        checks++; if (ovr_seen !== 1'b0) begin errors++; $display("FAIL empty_overrun got %0b want 0", ovr_seen); end
    endtask

    task automatic test_drain3();
        ent_t e;
        logic rdy;
        int   n;
        for (int i = 0; i < 3; i++) begin
            e.a = AW'(10 * (i + 1));
            e.d = DW'(1);
            push(e, rdy);
            checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL drain3_ready%0d got %0b want 1", i, rdy); end
            model_q.push_back(e);
        end
        n = model_q.size();
        run_frame(1'b0, '0);
        exp_frames++;
        checks++; if (obs_w.size() != n) begin errors++; $display("FAIL drain3_count got %0d want %0d", obs_w.size(), n); end
        for (int i = 0; i < n && i < obs_w.size(); i++) begin
            checks++; if (obs_w[i] !== model_q[i] || obs_wc[i] != i + 2) begin errors++; $display("FAIL drain3_write%0d got a=%0d d=%0d cyc=%0d want a=%0d d=%0d cyc=%0d", i, obs_w[i].a, obs_w[i].d, obs_wc[i], model_q[i].a, model_q[i].d, i + 2); end
        end
        checks++; if (start_cyc != n + 2) begin errors++; $display("FAIL drain3_start got %0d want %0d", start_cyc, n + 2); end
        checks++; if (frame_count_o !== 16'(exp_frames)) begin errors++; $display("FAIL drain3_frames got %0d want %0d", frame_count_o, exp_frames); end
        model_q.delete();
    endtask

    task automatic test_full_fifo();
        ent_t e, inj;
        logic rdy, exp_rdy;
        for (int i = 0; i < D + 1; i++) begin
            e = rand_ent();
            exp_rdy = (model_q.size() < D);
            push(e, rdy);
            checks++; if (rdy !== exp_rdy) begin errors++; $display("FAIL full_ready%0d got %0b want %0b", i, rdy, exp_rdy); end
            if (exp_rdy) model_q.push_back(e);
        end
        checks++; if (brush_ready_o !== 1'b0) begin errors++; $display("FAIL full_ready_idle got %0b want 0", brush_ready_o); end
        inj = rand_ent();
        run_frame(1'b1, inj);
        exp_frames++;
        checks++; if (obs_w.size() != D) begin errors++; $display("FAIL full_count got %0d want %0d", obs_w.size(), D); end
        for (int i = 0; i < D && i < obs_w.size(); i++) begin
            checks++; if (obs_w[i] !== model_q[i] || obs_wc[i] != i + 2) begin errors++; $display("FAIL full_write%0d got a=%0d d=%0d cyc=%0d want a=%0d d=%0d cyc=%0d", i, obs_w[i].a, obs_w[i].d, obs_wc[i], model_q[i].a, model_q[i].d, i + 2); end
        end
        checks++; if (inj_ready !== 1'b1) begin errors++; $display("FAIL full_push_during_pop got %0b want 1", inj_ready); end
        checks++; if (start_cyc != D + 2) begin errors++; $display("FAIL full_start got %0d want %0d", start_cyc, D + 2); end
        model_q.delete();
        model_q.push_back(inj);
        checks++; if (brush_ready_o !== 1'b1) begin errors++; $display("FAIL full_ready_after got %0b want 1", brush_ready_o); end
        run_frame(1'b0, '0);
        exp_frames++;
        checks++; if (obs_w.size() != 1 || obs_w[0] !== inj || start_cyc != 3) begin errors++; $display("FAIL full_next_frame got n=%0d start=%0d want n=1 a=%0d start=3", obs_w.size(), start_cyc, inj.a); end
        checks++; if (frame_count_o !== 16'(exp_frames)) begin errors++; $display("FAIL full_frames got %0d want %0d", frame_count_o, exp_frames); end
        model_q.delete();
    endtask

    task automatic test_random_frames();
        ent_t e;
        logic rdy;
        int   n;
        for (int it = 0; it < 4; it++) begin
            n = $urandom_range(0, D);
            for (int i = 0; i < n; i++) begin
                e = rand_ent();
                push(e, rdy);
                model_q.push_back(e);
                repeat ($urandom_range(0, 2)) tick();
            end
            run_frame(1'b0, '0);
            exp_frames++;
            checks++; if (obs_w.size() != n || start_cyc != n + 2) begin errors++; $display("FAIL rand%0d_shape got n=%0d start=%0d want n=%0d start=%0d", it, obs_w.size(), start_cyc, n, n + 2); end
            for (int i = 0; i < n && i < obs_w.size(); i++) begin
                checks++; if (obs_w[i] !== model_q[i]) begin errors++; $display("FAIL rand%0d_write%0d got a=%0d d=%0d want a=%0d d=%0d", it, i, obs_w[i].a, obs_w[i].d, model_q[i].a, model_q[i].d); end
            end
            checks++; if (frame_count_o !== 16'(exp_frames)) begin errors++; $display("FAIL rand%0d_frames got %0d want %0d", it, frame_count_o, exp_frames); end
            model_q.delete();
        end
    endtask

    task automatic test_sand_ignored();
        sand_wr_ena_i     = 1'b1;
        sand_write_addr_i = AW'($urandom_range(1, MAXPIX));
        sand_write_data_i = 1'b1;
        sand_read_addr_i  = AW'($urandom_range(0, MAXPIX));
        disp_addr_i       = AW'($urandom_range(0, MAXPIX));
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (ram_wr_ena_o !== 1'b0 || ram_write_addr_o !== '0) begin errors++; $display("FAIL idle_wport%0d got en=%0b a=%0d want 0/0", i, ram_wr_ena_o, ram_write_addr_o); end
        end
        checks++; if (ram_read_addr_o !== disp_addr_i) begin errors++; $display("FAIL idle_rdaddr got %0d want %0d", ram_read_addr_o, disp_addr_i); end
        sand_done_i = 1'b1;
        tick();
        sand_done_i = 1'b0;
        tick();
        checks++; if (frame_count_o !== 16'(exp_frames) || busy_o !== 1'b0) begin errors++; $display("FAIL idle_done got frames=%0d busy=%0b want %0d/0", frame_count_o, busy_o, exp_frames); end
        sand_wr_ena_i = 1'b0;
    endtask

    task automatic test_overrun();
        int ovr_n = 0;
        int starts = 0;
        vblank_i = 1'b1;
        tick(); tick();
        checks++; if (sand_start_o !== 1'b1) begin errors++; $display("FAIL ovr_start got %0b want 1", sand_start_o); end
        tick();
        for (int k = 0; k < 6; k++) begin
            sand_read_addr_i  = AW'($urandom_range(0, MAXPIX));
            sand_write_addr_i = AW'($urandom_range(0, MAXPIX));
            sand_write_data_i = DW'($urandom);
            sand_wr_ena_i     = 1'($urandom);
            disp_addr_i       = AW'($urandom_range(0, MAXPIX));
            if (k == 1) vblank_i = 1'b0;
            if (k == 4) vblank_i = 1'b1;
            #1;
            if (overrun_o) ovr_n++;
            checks++; if (ram_read_addr_o !== sand_read_addr_i || ram_wr_ena_o !== sand_wr_ena_i || ram_write_addr_o !== sand_write_addr_i || ram_write_data_o !== sand_write_data_i) begin errors++; $display("FAIL ovr_mirror%0d got r=%0d w=%0d en=%0b want r=%0d w=%0d en=%0b", k, ram_read_addr_o, ram_write_addr_o, ram_wr_ena_o, sand_read_addr_i, sand_write_addr_i, sand_wr_ena_i); end
            tick();
        end
        if (overrun_o) ovr_n++;
        checks++; if (ovr_n != 1) begin errors++; $display("FAIL ovr_pulses got %0d want 1", ovr_n); end
        sand_wr_ena_i = 1'b0;
        sand_done_i = 1'b1;
        tick();
        sand_done_i = 1'b0;
        exp_frames++;
        checks++; if (frame_count_o !== 16'(exp_frames) || busy_o !== 1'b0) begin errors++; $display("FAIL ovr_done got frames=%0d busy=%0b want %0d/0", frame_count_o, busy_o, exp_frames); end
        for (int i = 0; i < 4; i++) begin
            tick();
            if (sand_start_o || busy_o) starts++;
        end
        checks++; if (starts != 0) begin errors++; $display("FAIL ovr_busy_rise_queued got %0d active cycles want 0", starts); end
        vblank_i = 1'b0;
        tick(); tick();
    endtask

    task automatic test_reset_mid_drain();
        ent_t e;
        logic rdy;
        for (int i = 0; i < 5; i++) begin
            e = rand_ent();
            push(e, rdy);
        end
        vblank_i = 1'b1;
        tick(); tick(); tick();
        checks++; if (busy_o !== 1'b1 || ram_wr_ena_o !== 1'b1) begin errors++; $display("FAIL rst_mid_pre got busy=%0b en=%0b want 1/1", busy_o, ram_wr_ena_o); end
        #2;
        reset_i = 1'b1;
        #1;
        checks++; if (busy_o !== 1'b0 || ram_wr_ena_o !== 1'b0 || ram_write_addr_o !== '0 || sand_start_o !== 1'b0) begin errors++; $display("FAIL rst_mid_async got busy=%0b en=%0b a=%0d st=%0b want 0/0/0/0", busy_o, ram_wr_ena_o, ram_write_addr_o, sand_start_o); end
        checks++; if (brush_ready_o !== 1'b1 || frame_count_o !== 16'd0 || overrun_o !== 1'b0) begin errors++; $display("FAIL rst_mid_state got rdy=%0b frames=%0d ovr=%0b want 1/0/0", brush_ready_o, frame_count_o, overrun_o); end
        tick();
        reset_i  = 1'b0;
        vblank_i = 1'b0;
        model_q.delete();
        exp_frames = 0;
        tick();
        run_frame(1'b0, '0);
        exp_frames++;
        checks++; if (obs_w.size() != 0 || start_cyc != 2) begin errors++; $display("FAIL rst_mid_next got n=%0d start=%0d want 0/2", obs_w.size(), start_cyc); end
        checks++; if (frame_count_o !== 16'(exp_frames)) begin errors++; $display("FAIL rst_mid_frames got %0d want %0d", frame_count_o, exp_frames); end
    endtask

`ifdef SAND_PAUSE_EN
    task automatic test_pause();
        ent_t e;
        logic rdy;
        for (int i = 0; i < 2; i++) begin
            e = rand_ent();
            push(e, rdy);
            model_q.push_back(e);
        end
        pause_i = 1'b1;
        run_frame(1'b0, '0);
        pause_i = 1'b0;
        checks++; if (obs_w.size() != 2 || start_n != 0) begin errors++; $display("FAIL pause_shape got n=%0d starts=%0d want 2/0", obs_w.size(), start_n); end
        for (int i = 0; i < 2 && i < obs_w.size(); i++) begin
            checks++; if (obs_w[i] !== model_q[i]) begin errors++; $display("FAIL pause_write%0d got a=%0d want a=%0d", i, obs_w[i].a, model_q[i].a); end
        end
        checks++; if (frame_count_o !== 16'(exp_frames) || busy_o !== 1'b0) begin errors++; $display("FAIL pause_frames got %0d busy=%0b want %0d/0", frame_count_o, busy_o, exp_frames); end
        model_q.delete();
    endtask
`endif

    initial begin
        test_reset();
        test_empty_frame();
        test_drain3();
        test_full_fifo();
        test_random_frames();
        test_sand_ignored();
        test_overrun();
`ifdef SAND_PAUSE_EN
        test_pause();
`endif
        test_reset_mid_drain();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sand_frame_scheduler.md
# sand_frame_scheduler

Frame-level scheduler that owns the pixel RAM write port and the sand engine's start/done handshake. Once per vertical blanking interval it drains queued brush (user paint) writes into the pixel RAM and then launches one sand-update pass, routing the sand engine's addresses to the RAM. Outside that window, the display scan-out owns the RAM read port. It sits between the VGA timing generator, the brush input logic, the sand update engine and the simple-dual-port pixel RAM.

## Interface
Parameters:
- ACTIVE_COLUMNS, 640, visible pixels per row
- ACTIVE_ROWS, 480, visible rows
- ADDR_WIDTH, $clog2(ACTIVE_COLUMNS*ACTIVE_ROWS), pixel address width
- DATA_WIDTH, 1, bits per pixel
- BRUSH_DEPTH, 8, brush FIFO entries (power of two)

Ports (reset reset_i, asynchronous, active-high; clock clk_i):
- clk_i  in  1  system clock
- reset_i  in  1  async active-high reset
- vblank_i  in  1  high during vertical blanking; synchronous to clk_i
- disp_addr_i  in  ADDR_WIDTH  scan-out read address
- brush_valid_i  in  1  brush write request
- brush_addr_i  in  ADDR_WIDTH  brush pixel address
- brush_data_i  in  DATA_WIDTH  brush pixel value
- brush_ready_o  out  1  FIFO not full; a push occurs when valid & ready
- sand_start_o  out  1  one-cycle start pulse to the sand engine
- sand_read_addr_i  in  ADDR_WIDTH  sand engine read address
- sand_write_addr_i  in  ADDR_WIDTH  sand engine write address
- sand_write_data_i  in  DATA_WIDTH  sand engine write data
- sand_wr_ena_i  in  1  sand engine write enable
- sand_done_i  in  1  one-cycle pass-complete pulse
- ram_read_addr_o  out  ADDR_WIDTH  RAM read address (1-cycle read latency)
- ram_write_addr_o  out  ADDR_WIDTH  RAM write address
- ram_write_data_o  out  DATA_WIDTH  RAM write data
- ram_wr_ena_o  out  1  RAM write enable
- busy_o  out  1  high in any state other than IDLE
- overrun_o  out  1  one-cycle pulse when vblank_i falls while busy
- frame_count_o  out  16  completed sand passes, wraps at 0xFFFF→0

## Operation
- Rising-edge detector: vblank_q registered; rise = vblank_i & ~vblank_q; fall = ~vblank_i & vblank_q.
- States: IDLE, DRAIN, SAND_START, SAND_RUN.
- IDLE: on rise, snapshot the FIFO occupancy into drain_cnt. If drain_cnt ≠ 0, go to DRAIN; otherwise go to SAND_START.
- DRAIN: pop the FIFO head each cycle and write it: ram_wr_ena_o=1, address/data = head. Decrement drain_cnt. When drain_cnt reaches 1, go to SAND_START. Entries pushed after the snapshot wait for the next frame.
- SAND_START: sand_start_o=1 for exactly one cycle, then go to SAND_RUN.
- SAND_RUN: RAM read/write ports mirror the sand_* inputs combinationally. On sand_done_i, increment frame_count_o and go to IDLE.
- Read-port mux: ram_read_addr_o = sand_read_addr_i in SAND_RUN, else disp_addr_i. Display data read during an overrun is undefined; tearing is accepted.
- Write port outside DRAIN and SAND_RUN: ram_wr_ena_o=0, addr/data=0. sand_wr_ena_i is ignored outside SAND_RUN.
- sand_done_i outside SAND_RUN is ignored.
- Overrun: fall while busy_o pulses overrun_o. The state machine does not abort; the pass completes normally.
- Rise while busy (vblank too short for a full cycle) is ignored; no frame is queued.
- FIFO: a simultaneous push and pop in DRAIN is legal. Occupancy is unchanged and brush_ready_o reflects not-full.

## Timing
- Reset values: state IDLE, FIFO empty, brush_ready_o=1, sand_start_o=0, ram_wr_ena_o=0, ram addresses/data 0, busy_o=0, overrun_o=0, frame_count_o=0, vblank_q=0.
- Rise is detected in the cycle after vblank_i goes high. First DRAIN write or sand_start_o occurs in the following cycle (2 cycles after vblank_i goes high).
- Drain of N entries takes N cycles; sand_start_o follows 1 cycle after the last write.
- Brush push to FIFO head: 1 cycle.
- RAM address/enable outputs are combinational from state plus FIFO head or sand inputs; no added latency to the sand engine's 1-cycle read path.
- Reset mid-operation empties the FIFO and returns to IDLE immediately. The sand engine is reset by the same reset_i.

## Configuration
- SAND_PAUSE_EN defined: adds input pause_i (1 bit). If pause_i=1 at rise, the brush drain still runs, then the block returns to IDLE without pulsing sand_start_o; frame_count_o is unchanged.
- Undefined: no pause_i port; a sand pass runs every frame.

## Structure
- Shared package sand_pkg: the state enum typedef and default ACTIVE_COLUMNS/ACTIVE_ROWS constants, shared with the sand engine and VGA timing.
- One sub-module: brush_fifo, a synchronous FIFO with parameterised depth and width ADDR_WIDTH+DATA_WIDTH, exposing full, empty, count and head.

## Test plan
- Reset, then one vblank rise with an empty FIFO → no writes; sand_start_o pulses 2 cycles after the rise; sand_done_i → frame_count_o=1, busy_o=0.
- Push 3 brush writes (addr 10/20/30, data 1) before vblank → 3 consecutive RAM writes in push order, then sand_start_o on the next cycle.
- Fill the FIFO to 8 → brush_ready_o=0 and a 9th valid is not accepted. During DRAIN, a push in the same cycle as a pop is accepted; the new entry is not written until the next frame.
- vblank_i falls during SAND_RUN → one-cycle overrun_o; the pass completes and frame_count_o increments; ram_read_addr_o follows the sand engine until done.
- sand_wr_ena_i=1 while IDLE → ram_wr_ena_o stays 0; sand_done_i while IDLE → frame_count_o unchanged.
- Assert reset_i mid-DRAIN with 5 entries queued → outputs return to reset values asynchronously; the next frame performs no brush writes.
